// File: rtl/exec_seq_pkg.sv
// Shared types and encodings for the exec_seq RV32 OP/OP-IMM sequencer.
package exec_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWb
    } state_e;

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;

    localparam logic [2:0] F3Add  = 3'b000;
    localparam logic [2:0] F3Xor  = 3'b100;
    localparam logic [2:0] F3Or   = 3'b110;
    localparam logic [2:0] F3And  = 3'b111;
    localparam logic [2:0] F3Hold = 3'b001;

    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Sub  = 7'b0100000;

    function automatic logic f3_supported(input logic [2:0] f3);
        return (f3 == F3Add) || (f3 == F3Xor) || (f3 == F3Or) || (f3 == F3And);
    endfunction

endpackage

// File: rtl/exec_seq_dec.sv
// Combinational decode and legality check for exec_seq.
// OP-IMM is accepted only when EXEC_SEQ_IMM_EN is defined.
module exec_seq_dec
    import exec_seq_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic        o_legal,
    output logic        o_is_imm,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic [2:0]  o_funct3,
    output logic [6:0]  o_funct7,
    output logic [31:0] o_imm
);
    logic [6:0] w_opcode;
    logic [6:0] w_f7_raw;

    assign w_opcode = i_instr[6:0];
    assign w_f7_raw = i_instr[31:25];
    assign o_rs1    = i_instr[19:15];
    assign o_rd     = i_instr[11:7];
    assign o_funct3 = i_instr[14:12];
    assign o_imm    = {{20{i_instr[31]}}, i_instr[31:20]};

    always_comb begin
        o_legal  = 1'b0;
        o_is_imm = 1'b0;
        o_rs2    = i_instr[24:20];
        o_funct7 = w_f7_raw;
        if (w_opcode == OpcOp) begin
            o_legal = f3_supported(o_funct3) &&
                      ((w_f7_raw == F7Zero) || ((w_f7_raw == F7Sub) && (o_funct3 == F3Add)));
`ifdef EXEC_SEQ_IMM_EN
        end else if (w_opcode == OpcOpImm) begin
            // Upper bits belong to the immediate, so there is no SUBI and no rs2 read.
            o_legal  = f3_supported(o_funct3);
            o_is_imm = 1'b1;
            o_rs2    = 5'd0;
            o_funct7 = F7Zero;
`endif
        end
    end

endmodule

// File: rtl/exec_seq.sv
// Four-state sequencer driving register file and external registered ALU.
// Define EXEC_SEQ_IMM_EN to accept OP-IMM instructions.
module exec_seq
    import exec_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    output logic [2:0]      alu_funct3,
    output logic [6:0]      alu_funct7,
    output logic [XLEN-1:0] alu_op_a,
    output logic [XLEN-1:0] alu_op_b,
    input  logic [XLEN-1:0] alu_rd,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic            busy,
    output logic            illegal
);
    state_e r_state, w_state_next;

    logic        w_legal, w_is_imm, w_accept;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm;

    logic            r_illegal, r_is_imm;
    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic [2:0]      r_funct3;
    logic [6:0]      r_funct7;
    logic [XLEN-1:0] r_imm, r_op_a, r_op_b;

    exec_seq_dec u_dec (
        .i_instr  (instr),
        .o_legal  (w_legal),
        .o_is_imm (w_is_imm),
        .o_rs1    (w_rs1),
        .o_rs2    (w_rs2),
        .o_rd     (w_rd),
        .o_funct3 (w_funct3),
        .o_funct7 (w_funct7),
        .o_imm    (w_imm)
    );

    assign w_accept = instr_valid && (r_state == StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
            r_is_imm  <= 1'b0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_funct3  <= '0;
            r_funct7  <= '0;
            r_imm     <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_is_imm <= w_is_imm;
                r_rs1    <= w_rs1;
                r_rs2    <= w_rs2;
                r_rd     <= w_rd;
                r_funct3 <= w_funct3;
                r_funct7 <= w_funct7;
                r_imm    <= w_imm;
            end
            if (r_state == StRead) begin
                r_op_a <= rf_rs1_data;
                r_op_b <= r_is_imm ? r_imm : rf_rs2_data;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        instr_ready  = 1'b0;
        busy         = 1'b1;
        illegal      = r_illegal;
        rf_rs1_addr  = '0;
        rf_rs2_addr  = '0;
        alu_funct3   = F3Hold;
        alu_funct7   = F7Zero;
        alu_op_a     = '0;
        alu_op_b     = '0;
        rf_we        = 1'b0;
        rf_wa        = '0;
        rf_wd        = '0;
        unique case (r_state)
            StIdle: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (w_accept && w_legal) begin
                    w_state_next = StRead;
                end
            end
            StRead: begin
                rf_rs1_addr  = r_rs1;
                rf_rs2_addr  = r_rs2;
                w_state_next = StExec;
            end
            StExec: begin
                alu_funct3   = r_funct3;
                alu_funct7   = r_funct7;
                alu_op_a     = r_op_a;
                alu_op_b     = r_op_b;
                w_state_next = StWb;
            end
            StWb: begin
                // x0 is hardwired zero, so its write is suppressed here.
                rf_we        = (r_rd != 5'd0);
                rf_wa        = r_rd;
                rf_wd        = alu_rd;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

endmodule

// File: tb/tb_exec_seq.sv
// Self-checking bench for exec_seq with a register-file model and a registered ALU model.
module tb_exec_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic [2:0]  alu_funct3;
    logic [6:0]  alu_funct7;
    logic [31:0] alu_op_a, alu_op_b;
    logic [31:0] alu_rd = 32'h0;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        busy;
    logic        illegal;

    logic [31:0] rf_mem [32];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exec_seq #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_rs1_addr (rf_rs1_addr),
        .rf_rs2_addr (rf_rs2_addr),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_data (rf_rs2_data),
        .alu_funct3  (alu_funct3),
        .alu_funct7  (alu_funct7),
        .alu_op_a    (alu_op_a),
        .alu_op_b    (alu_op_b),
        .alu_rd      (alu_rd),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .busy        (busy),
        .illegal     (illegal)
    );

    assign rf_rs1_data = rf_mem[rf_rs1_addr];
    assign rf_rs2_data = rf_mem[rf_rs2_addr];

    // Registered ALU: unimplemented funct3 codes hold the previous result.
    always @(posedge clk) begin
        case (alu_funct3)
            3'b000:  alu_rd <= (alu_funct7 == 7'b0100000) ? alu_op_a - alu_op_b
                                                          : alu_op_a + alu_op_b;
            3'b100:  alu_rd <= alu_op_a ^ alu_op_b;
            3'b110:  alu_rd <= alu_op_a | alu_op_b;
            3'b111:  alu_rd <= alu_op_a & alu_op_b;
            default: alu_rd <= alu_rd;
        endcase
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] x1;
        logic [31:0] x2;
        bit          bad;
        logic [4:0]  rs2;
        logic [31:0] op_b;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // Returns at a falling edge with instr_ready high, or flags a timeout.
    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready", 32'(instr_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        rf_mem[1] = v.x1;
        rf_mem[2] = v.x2;
        wait_ready();
        instr       = v.instr;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        if (v.bad) begin
            check($sformatf("v%0d_illegal_pulse", idx), 32'(illegal), 32'd1);
            check($sformatf("v%0d_illegal_idle", idx), 32'(instr_ready), 32'd1);
            check($sformatf("v%0d_illegal_busy", idx), 32'(busy), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_illegal_end", idx), 32'(illegal), 32'd0);
        end else begin
            check($sformatf("v%0d_read_ready", idx), 32'(instr_ready), 32'd0);
            check($sformatf("v%0d_read_illegal", idx), 32'(illegal), 32'd0);
            check($sformatf("v%0d_read_rs1", idx), 32'(rf_rs1_addr), 32'(v.instr[19:15]));
            check($sformatf("v%0d_read_rs2", idx), 32'(rf_rs2_addr), 32'(v.rs2));
            check($sformatf("v%0d_read_we", idx), 32'(rf_we), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_exec_f3", idx), 32'(alu_funct3), 32'(v.instr[14:12]));
            check($sformatf("v%0d_exec_a", idx), alu_op_a, v.x1);
            check($sformatf("v%0d_exec_b", idx), alu_op_b, v.op_b);
            check($sformatf("v%0d_exec_we", idx), 32'(rf_we), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_wb_we", idx), 32'(rf_we), 32'(v.we));
            if (v.we) begin
                check($sformatf("v%0d_wb_wa", idx), 32'(rf_wa), 32'(v.wa));
                check($sformatf("v%0d_wb_wd", idx), rf_wd, v.wd);
            end
            @(negedge clk);
            check($sformatf("v%0d_done_ready", idx), 32'(instr_ready), 32'd1);
            check($sformatf("v%0d_done_we", idx), 32'(rf_we), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int accepted;
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;

        vecs[0] = '{rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7, 1'b0, 5'd2, 32'd7,
                    1'b1, 5'd3, 32'd12};
        vecs[1] = '{rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 32'd0, 32'd1, 1'b0, 5'd2, 32'd1,
                    1'b1, 5'd4, 32'hFFFFFFFF};
        vecs[2] = '{rtype(7'h00, 5'd2, 5'd1, 3'b100, 5'd5), 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0,
                    5'd2, 32'h0FF00FF0, 1'b1, 5'd5, 32'hFF00FF00};
        vecs[3] = '{rtype(7'h00, 5'd2, 5'd1, 3'b110, 5'd6), 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0,
                    5'd2, 32'h0FF00FF0, 1'b1, 5'd6, 32'hFFF0FFF0};
        vecs[4] = '{rtype(7'h00, 5'd2, 5'd1, 3'b111, 5'd7), 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0,
                    5'd2, 32'h0FF00FF0, 1'b1, 5'd7, 32'h00F000F0};
        vecs[5] = '{rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), 32'd5, 32'd7, 1'b0, 5'd2, 32'd7,
                    1'b0, 5'd0, 32'd0};
        vecs[6] = '{rtype(7'h00, 5'd2, 5'd1, 3'b001, 5'd3), 32'd5, 32'd7, 1'b1, 5'd0, 32'd0,
                    1'b0, 5'd0, 32'd0};
        vecs[7] = '{rtype(7'h20, 5'd2, 5'd1, 3'b100, 5'd3), 32'd5, 32'd7, 1'b1, 5'd0, 32'd0,
                    1'b0, 5'd0, 32'd0};
`ifdef EXEC_SEQ_IMM_EN
        vecs[8] = '{{12'hFFF, 5'd1, 3'b000, 5'd5, 7'b0010011}, 32'd1, 32'd9, 1'b0, 5'd0,
                    32'hFFFFFFFF, 1'b1, 5'd5, 32'd0};
`else
        vecs[8] = '{{12'hFFF, 5'd1, 3'b000, 5'd5, 7'b0010011}, 32'd1, 32'd9, 1'b1, 5'd0,
                    32'd0, 1'b0, 5'd0, 32'd0};
`endif

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_wa", 32'(rf_wa), 32'd0);
        check("rst_wd", rf_wd, 32'd0);
        check("rst_op_a", alu_op_a, 32'd0);
        check("rst_op_b", alu_op_b, 32'd0);
        check("rst_f7", 32'(alu_funct7), 32'd0);
        check("rst_f3", 32'(alu_funct3), 32'd1);
        check("rst_rs1", 32'(rf_rs1_addr), 32'd0);
        check("rst_rs2", 32'(rf_rs2_addr), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Valid held high: one acceptance per four cycles.
        rf_mem[1] = 32'd5;
        rf_mem[2] = 32'd7;
        wait_ready();
        instr       = vecs[0].instr;
        instr_valid = 1'b1;
        accepted    = 0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("b2b_ready_c%0d", i), 32'(instr_ready), 32'((i % 4) == 0));
            check($sformatf("b2b_we_c%0d", i), 32'(rf_we), 32'((i % 4) == 3));
            if (instr_valid && instr_ready) accepted++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("b2b_accepted", 32'(accepted), 32'd3);

        // Reset during EXEC aborts the write.
        wait_ready();
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("rexec_in_exec", 32'(alu_funct3), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rexec_busy", 32'(busy), 32'd0);
        check("rexec_ready", 32'(instr_ready), 32'd1);
        check("rexec_f3", 32'(alu_funct3), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rexec_we_c%0d", i), 32'(rf_we), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rexec_post_we_c%0d", i), 32'(rf_we), 32'd0);
        end
        run_vec(vecs[0], 20);

        // Reset during WB drops the write immediately.
        wait_ready();
        instr       = vecs[1].instr;
        rf_mem[1]   = vecs[1].x1;
        rf_mem[2]   = vecs[1].x2;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rwb_in_wb", 32'(rf_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rwb_we", 32'(rf_we), 32'd0);
        check("rwb_wd", rf_wd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rwb_post_we_c%0d", i), 32'(rf_we), 32'd0);
        end
        run_vec(vecs[2], 21);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
